// File: rtl/ks_adder_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder: prefix-cell
// operators plus the constant functions used to size the pipeline.
package ks_adder_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r++;
    end
    return r;
  endfunction

  function automatic int popcount(input logic [31:0] mask, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n && i < 32; i++) begin
      if (mask[i]) c++;
    end
    return c;
  endfunction

  function automatic pg_t black(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  // The low span already reaches the carry-in, whose propagate is 0,
  // so the combined propagate is known to be 0.
  function automatic pg_t grey(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One Kogge-Stone prefix level at a fixed distance, optionally followed by a
// pipeline register with its own valid bit and stall handling.
module ks_prefix_level
  import ks_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIST   = 1,
  parameter bit REG    = 1'b0,
  parameter int SIDE_W = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                up_valid,
  output logic                up_ready,
  input  pg_t  [WIDTH-1:0]    up_pg,
  input  logic [SIDE_W-1:0]   up_side,
  output logic                dn_valid,
  input  logic                dn_ready,
  output pg_t  [WIDTH-1:0]    dn_pg,
  output logic [SIDE_W-1:0]   dn_side
);

  pg_t [WIDTH-1:0]  nxt;
  logic             v;
  pg_t [WIDTH-1:0]  pg_q;
  logic [SIDE_W-1:0] side_q;

  // Positions below DIST are already complete and pass through unchanged.
  always_comb begin
    nxt = up_pg;
    for (int i = DIST; i < WIDTH; i++) begin
      if (i < 2 * DIST) nxt[i] = grey(up_pg[i], up_pg[i-DIST]);
      else              nxt[i] = black(up_pg[i], up_pg[i-DIST]);
    end
  end

  // Without REG the level is pure combinational and the register stays idle.
  always_ff @(posedge clk) begin
    if (rst || !REG) v <= 1'b0;
    else if (up_ready) v <= up_valid;
  end

  always_ff @(posedge clk) begin
    if (REG && up_valid && up_ready) begin
      pg_q   <= nxt;
      side_q <= up_side;
    end
  end

  assign up_ready = REG ? (!v || dn_ready) : dn_ready;
  assign dn_valid = REG ? v : up_valid;
  assign dn_pg    = REG ? pg_q : nxt;
  assign dn_side  = REG ? side_q : up_side;

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: input register, LEVELS prefix levels
// with optional registers between them, and a registered sum/carry/overflow.
module ks_adder_pipe
  import ks_adder_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] REG_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int LEVELS = clog2(WIDTH);
  // Side data per beat: raw propagate bits, then MSBs of A and effective B.
  localparam int SIDE_W = WIDTH + 2;

  // Handshake: a beat moves between stages on a cycle where the sender holds
  // valid and the receiver is ready; a stage is ready when empty or when its
  // own content leaves in the same cycle. Stalled stages hold everything.

  logic [WIDTH-1:0]  b_eff;
  pg_t [WIDTH-1:0]   pre_pg;
  logic [SIDE_W-1:0] pre_side;

  // Prefix position 0 is the carry-in (bit -1); position i covers bit i-1.
  always_comb begin
    b_eff = in_sub ? ~in_b : in_b;
    pre_pg = '0;
    pre_pg[0].g = in_sub | in_cin;
    for (int i = 1; i < WIDTH; i++) begin
      pre_pg[i].p = in_a[i-1] ^ b_eff[i-1];
      pre_pg[i].g = in_a[i-1] & b_eff[i-1];
    end
  end

  assign pre_side = {in_a ^ b_eff, in_a[WIDTH-1], b_eff[WIDTH-1]};

  logic              lv_valid [LEVELS+1];
  logic              lv_ready [LEVELS+1];
  pg_t [WIDTH-1:0]   lv_pg    [LEVELS+1];
  logic [SIDE_W-1:0] lv_side  [LEVELS+1];

  logic s0_v;

  assign in_ready = !rst && (!s0_v || lv_ready[0]);

  always_ff @(posedge clk) begin
    if (rst) s0_v <= 1'b0;
    else if (!s0_v || lv_ready[0]) s0_v <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      lv_pg[0]   <= pre_pg;
      lv_side[0] <= pre_side;
    end
  end

  assign lv_valid[0] = s0_v;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    ks_prefix_level #(
      .WIDTH  (WIDTH),
      .DIST   (1 << (k - 1)),
      .REG    (REG_MASK[k-1]),
      .SIDE_W (SIDE_W)
    ) u_level (
      .clk      (clk),
      .rst      (rst),
      .up_valid (lv_valid[k-1]),
      .up_ready (lv_ready[k-1]),
      .up_pg    (lv_pg[k-1]),
      .up_side  (lv_side[k-1]),
      .dn_valid (lv_valid[k]),
      .dn_ready (lv_ready[k]),
      .dn_pg    (lv_pg[k]),
      .dn_side  (lv_side[k])
    );
  end

  logic [WIDTH-1:0] fin_p;
  logic             fin_a_msb;
  logic             fin_b_msb;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  // Final G at position i is the carry into bit i; the top bit's own
  // generate/propagate folds in once more to give the carry-out.
  always_comb begin
    fin_p     = lv_side[LEVELS][SIDE_W-1:2];
    fin_a_msb = lv_side[LEVELS][1];
    fin_b_msb = lv_side[LEVELS][0];
    for (int i = 0; i < WIDTH; i++) begin
      sum_c[i] = fin_p[i] ^ lv_pg[LEVELS][i].g;
    end
    cout_c = (fin_a_msb & fin_b_msb) | (fin_p[WIDTH-1] & lv_pg[LEVELS][WIDTH-1].g);
    ovf_c  = (fin_a_msb == fin_b_msb) && (sum_c[WIDTH-1] != fin_a_msb);
  end

  assign lv_ready[LEVELS] = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      if (lv_ready[LEVELS]) out_valid <= lv_valid[LEVELS];
      if (lv_valid[LEVELS] && lv_ready[LEVELS]) begin
        out_sum  <= sum_c;
        out_cout <= cout_c;
        out_ovf  <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe: three configurations (16/mask 0, 32/mask 10101,
// 13/mask F) share one stimulus bus selected by sel.
module tb_ks_adder_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int sel      = 0;
  logic bp_en   = 1'b0;
  logic chk_lat = 1'b0;

  int cfg_w   [3] = '{16, 32, 13};
  int cfg_lat [3] = '{2, 5, 6};

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] bus_a = '0, bus_b = '0;
  logic        bus_cin = 1'b0, bus_sub = 1'b0, bus_iv = 1'b0, bus_or = 1'b1;
  logic        bus_ir, bus_ov, bus_cout, bus_ovf;
  logic [31:0] bus_sum;

  logic        d0_ir, d0_ov, d0_co, d0_of;
  logic [15:0] d0_sum;
  logic        d1_ir, d1_ov, d1_co, d1_of;
  logic [31:0] d1_sum;
  logic        d2_ir, d2_ov, d2_co, d2_of;
  logic [12:0] d2_sum;

  ks_adder_pipe #(.WIDTH(16), .REG_MASK(32'h0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(bus_iv && sel == 0), .in_ready(d0_ir),
    .in_a(bus_a[15:0]), .in_b(bus_b[15:0]), .in_cin(bus_cin), .in_sub(bus_sub),
    .out_valid(d0_ov), .out_ready(sel == 0 ? bus_or : 1'b1),
    .out_sum(d0_sum), .out_cout(d0_co), .out_ovf(d0_of));

  ks_adder_pipe #(.WIDTH(32), .REG_MASK(32'b10101)) dut1 (
    .clk(clk), .rst(rst), .in_valid(bus_iv && sel == 1), .in_ready(d1_ir),
    .in_a(bus_a), .in_b(bus_b), .in_cin(bus_cin), .in_sub(bus_sub),
    .out_valid(d1_ov), .out_ready(sel == 1 ? bus_or : 1'b1),
    .out_sum(d1_sum), .out_cout(d1_co), .out_ovf(d1_of));

  ks_adder_pipe #(.WIDTH(13), .REG_MASK(32'hF)) dut2 (
    .clk(clk), .rst(rst), .in_valid(bus_iv && sel == 2), .in_ready(d2_ir),
    .in_a(bus_a[12:0]), .in_b(bus_b[12:0]), .in_cin(bus_cin), .in_sub(bus_sub),
    .out_valid(d2_ov), .out_ready(sel == 2 ? bus_or : 1'b1),
    .out_sum(d2_sum), .out_cout(d2_co), .out_ovf(d2_of));

  always_comb begin
    bus_ir = d0_ir; bus_ov = d0_ov; bus_cout = d0_co; bus_ovf = d0_of;
    bus_sum = {16'b0, d0_sum};
    case (sel)
      1: begin
        bus_ir = d1_ir; bus_ov = d1_ov; bus_cout = d1_co; bus_ovf = d1_of;
        bus_sum = d1_sum;
      end
      2: begin
        bus_ir = d2_ir; bus_ov = d2_ov; bus_cout = d2_co; bus_ovf = d2_of;
        bus_sum = {19'b0, d2_sum};
      end
      default: ;
    endcase
  end

  // Reference: unsigned sum gives sum/carry, signed sum gives overflow.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    longint m, half, ua, ub, ci, full, sa, sb, s;
    logic [31:0] sm;
    logic co, ov;
    m    = (longint'(1) <<< w) - 1;
    half = longint'(1) <<< (w - 1);
    ua   = longint'(a) & m;
    ub   = (sub ? longint'(~b) : longint'(b)) & m;
    ci   = (sub || cin) ? 1 : 0;
    full = ua + ub + ci;
    sm   = 32'(full & m);
    co   = ((full >>> w) & 1) != 0;
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sb   = (ub >= half) ? ub - (m + 1) : ub;
    s    = sa + sb + ci;
    ov   = (s > half - 1) || (s < -half);
    return {ov, co, sm};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Scoreboard / monitor, sampled on the falling edge.
  logic [33:0] exp_q[$];
  int          t_q[$];
  logic        prev_stall = 1'b0;
  logic [33:0] prev_out = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", bus_ov, 1);
        check("hold_data", {bus_ovf, bus_cout, bus_sum}, prev_out);
      end
      if (!bus_ir) begin
        check("ready_low_out_stalled", {bus_ov, bus_or}, 2'b10);
        check("ready_low_pipe_full", exp_q.size(), cfg_lat[sel]);
      end
      if (bus_ov && bus_or) begin
        if (exp_q.size() == 0) begin
          fail_now($sformatf("spurious_out sum=%0h", bus_sum));
        end else begin
          logic [33:0] e;
          int t;
          e = exp_q.pop_front();
          t = t_q.pop_front();
          check("result", {bus_ovf, bus_cout, bus_sum}, e);
          if (chk_lat) check("latency", cyc - t, cfg_lat[sel]);
        end
      end
      if (bus_iv && bus_ir) begin
        exp_q.push_back(model(cfg_w[sel], bus_a, bus_b, bus_cin, bus_sub));
        t_q.push_back(cyc);
      end
      prev_stall = bus_ov && !bus_or;
      prev_out   = {bus_ovf, bus_cout, bus_sum};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus_or = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic sub, input int gap);
    int guard;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus_a = a; bus_b = b; bus_cin = cin; bus_sub = sub; bus_iv = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bus_ir && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus_ir) fail_now("in_ready_timeout");
    @(posedge clk);
    #1;
    bus_iv = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    @(negedge clk);
    while (!bus_ov && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat;
    vecs[0]  = '{32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0};
    vecs[1]  = '{32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1};
    vecs[2]  = '{32'h0005, 32'h0007, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0};
    vecs[3]  = '{32'h0007, 32'h0005, 1'b0, 1'b1, 32'h0002, 1'b1, 1'b0};
    vecs[4]  = '{32'hFFFF, 32'hFFFF, 1'b1, 1'b0, 32'hFFFF, 1'b1, 1'b0};
    vecs[5]  = '{32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1};
    vecs[6]  = '{32'h0000, 32'h0000, 1'b1, 1'b0, 32'h0001, 1'b0, 1'b0};
    vecs[7]  = '{32'h0000, 32'h0000, 1'b0, 1'b1, 32'h0000, 1'b1, 1'b0};
    vecs[8]  = '{32'h1234, 32'h4321, 1'b0, 1'b0, 32'h5555, 1'b0, 1'b0};
    vecs[9]  = '{32'h0000, 32'h8000, 1'b0, 1'b1, 32'h8000, 1'b0, 1'b1};
    vecs[10] = '{32'h4000, 32'h4000, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1};
    vecs[11] = '{32'h0003, 32'h0003, 1'b1, 1'b1, 32'h0000, 1'b1, 1'b0};

    // Reset state
    sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus_ir, 0);
    check("rst_out_valid", bus_ov, 0);
    check("rst_outputs", {bus_ovf, bus_cout, bus_sum}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", bus_ir, 1);
    @(posedge clk);
    #1;

    // Directed table on 16-bit, REG_MASK=0
    chk_lat = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0);
      wait_out(lat);
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_sum", i), bus_sum, vecs[i].sum);
      check($sformatf("vec%0d_cout", i), bus_cout, vecs[i].cout);
      check($sformatf("vec%0d_ovf", i), bus_ovf, vecs[i].ovf);
      @(posedge clk);
      #1;
    end
    drain();

    // 32-bit back-to-back, full throughput, fixed latency
    sel = 1;
    for (int i = 0; i < 100; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    drain();

    // Backpressure on 32-bit and 13-bit
    chk_lat = 1'b0;
    bp_en = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      sel = c;
      for (int i = 0; i < 600; i++)
        send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      drain();
    end
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset with three beats in flight on the 32-bit pipe
    sel = 1;
    chk_lat = 1'b1;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0, 0);
    rst = 1'b1;
    exp_q.delete();
    t_q.delete();
    @(negedge clk);
    check("midrst_in_ready", bus_ir, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", bus_ov, 0);
    check("midrst_ready_after", bus_ir, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale_beat", bus_ov, 0);
    end
    @(posedge clk);
    #1;
    send(32'hDEADBEEF, 32'h11111111, 1'b1, 1'b0, 0);
    wait_out(lat);
    check("post_rst_latency", lat, 5);
    check("post_rst_sum", {bus_ovf, bus_cout, bus_sum}, {1'b0, 1'b0, 32'hEFBED001});
    @(posedge clk);
    #1;
    drain();

    // 13-bit, long random run with cin/sub toggling
    sel = 2;
    for (int i = 0; i < 10000; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
